// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ROTL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(alu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: moves the accumulator one bit position per step.
// Reports the final step so the caller can capture acc_next directly.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  alu_op_e          op_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    amt_in,
  output logic [WIDTH:0]   acc_next,
  output logic             last
);

  logic [WIDTH:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  alu_op_e        op_q, op_d;

  // ROTL wraps bit WIDTH-1 back to bit 0 and keeps bit WIDTH clear.
  always_comb begin
    acc_next = acc_q;
    case (op_q)
      OP_SHL:  acc_next = {acc_q[WIDTH-1:0], 1'b0};
      OP_SHR:  acc_next = {1'b0, acc_q[WIDTH:1]};
      OP_ROTL: acc_next = {1'b0, acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
      default: acc_next = acc_q;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (load) begin
      acc_d = {1'b0, data_in};
      cnt_d = amt_in;
      op_d  = op_in;
    end else if (step) begin
      acc_d = acc_next;
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= OP_ADD;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes, registered flags and an
// iterative shift/rotate engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  alu_state_e     state_q, state_d;
  logic [WIDTH:0] result_q, result_d;
  logic           zero_q, zero_d;
  logic           carry_q, carry_d;
  logic           overflow_q, overflow_d;

  alu_op_e        op;
  logic [CW-1:0]  amt;
  logic [WIDTH:0] a_ext, b_ext;
  logic [WIDTH:0] sp_result;
  logic           sp_ovf;
  logic [WIDTH:0] sh_next;
  logic           sh_last;
  logic           sh_load, sh_step;
  logic           capture;

  assign op    = alu_op_e'(opcode);
  assign amt   = in2[CW-1:0];
  assign a_ext = {1'b0, in1};
  assign b_ext = {1'b0, in2};

  always_comb begin
    sp_result = '0;
    sp_ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        sp_result = a_ext + b_ext;
        sp_ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) && (sp_result[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        sp_result = a_ext - b_ext;
        sp_ovf    = (in1[WIDTH-1] != in2[WIDTH-1]) && (sp_result[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  sp_result = a_ext & b_ext;
      OP_OR:   sp_result = a_ext | b_ext;
      OP_XOR:  sp_result = a_ext ^ b_ext;
      default: sp_result = '0;
    endcase
  end

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .step     (sh_step),
    .op_in    (op),
    .data_in  (in1),
    .amt_in   (amt),
    .acc_next (sh_next),
    .last     (sh_last)
  );

  // zero/carry are derived from whatever result is captured this cycle.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    sh_load    = 1'b0;
    sh_step    = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (!is_shift_op(op)) begin
            result_d   = sp_result;
            overflow_d = sp_ovf;
            capture    = 1'b1;
            state_d    = ST_DONE;
          end else if (amt == '0) begin
            result_d   = a_ext;
            overflow_d = 1'b0;
            capture    = 1'b1;
            state_d    = ST_DONE;
          end else begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_d   = sh_next;
          overflow_d = 1'b0;
          capture    = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      zero_d  = (result_d[WIDTH-1:0] == '0);
      carry_d = result_d[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE) && !rst;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's 5-bit registered ALU. It executes the same eight-opcode set on WIDTH-bit operands and adds three things: registered status flags, valid/ready handshakes on input and output, and an iterative one-bit-per-cycle shift/rotate engine in place of a combinational barrel shifter. It sits between the operand/opcode issue stage and the writeback stage.

## Interface
Parameters:
- WIDTH, default 8: operand width. Must be a power of two and at least 4.

Ports:
- clk  in  1  clock; every state change happens on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  opcode and operands are valid.
- in_ready  out  1  block can accept an operation.
- opcode  in  3  operation select; encoding below.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B, or the shift amount for shift/rotate ops.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH+1  registered result.
- zero  out  1  high when result[WIDTH-1:0] == 0.
- carry  out  1  copy of result[WIDTH].
- overflow  out  1  signed overflow; meaningful for ADD and SUB only.

## Operation
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR: single-pass ops.
  - 101 SHL, 110 SHR, 111 ROTL: iterative ops.
- Arithmetic and width rules (all in WIDTH+1 bits):
  - Both operands are zero-extended to WIDTH+1 bits.
  - ADD: result[WIDTH] is the carry out.
  - SUB: result = in1 - in2 mod 2^(WIDTH+1); result[WIDTH] = 1 exactly when in1 < in2 (borrow).
  - AND/OR/XOR: result[WIDTH] = 0.
- Shift amount: amt = in2 mod WIDTH, taken from in2[$clog2(WIDTH)-1:0].
  - SHL: zero-extended in1 shifted left by amt within WIDTH+1 bits. Bits leaving bit WIDTH are lost.
  - SHR: logical right shift by amt.
  - ROTL: rotate left by amt within the low WIDTH bits; result[WIDTH] = 0.
- Flags, registered together with result:
  - zero: high when the low WIDTH bits of result are 0.
  - carry = result[WIDTH].
  - overflow, ADD: operand sign bits equal and the sum's sign bit differs from them.
  - overflow, SUB: operand sign bits differ and the difference's sign bit differs from in1's.
  - overflow = 0 for all other opcodes.
- State machine (states IDLE, SHIFT, DONE):
  - IDLE: in_ready = 1. A transfer occurs when in_valid && in_ready. The block latches opcode and operands.
    - Single-pass op: result computed and registered, next state DONE.
    - Shift op with amt == 0: result = zero-extended in1, next state DONE.
    - Shift op with amt > 0: accumulator loaded with in1, counter loaded with amt, next state SHIFT.
  - SHIFT: one bit position per cycle; counter decrements. When the counter reaches 0, the accumulator is registered into result/flags and the next state is DONE.
  - DONE: out_valid = 1. result and flags are held stable until out_ready = 1, then the next state is IDLE.
- in_ready is 0 in SHIFT and DONE. in_valid in those states is ignored, with no queueing.

## Timing
- Reset: while rst is high, the following are forced and held:
  - state = IDLE, result = 0, zero/carry/overflow = 0, out_valid = 0.
  - in_ready = 0 (in_ready = (state == IDLE) && !rst).
  - in_ready = 1 in the first cycle after rst deasserts.
- Latency, measured from the accept edge to out_valid high:
  - Single-pass op: 1 cycle.
  - Shift op: amt + 1 cycles (amt = 0 gives 1 cycle).
- Throughput: at most one operation per (latency + 1) cycles. An output handshake and a new input accept never occur in the same cycle.
- out_valid must not drop before out_ready. result must not change while out_valid = 1.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned and its result is never presented.
- Counter width is $clog2(WIDTH). It does not wrap because amt ≤ WIDTH-1.

## Structure
- Shared package alu_pkg:
  - alu_op_e enum (3-bit opcode encodings).
  - alu_state_e enum (IDLE, SHIFT, DONE).
- One sub-module, alu_shift_unit: accumulator, counter and SHL/SHR/ROTL step logic, with load/step/done signals. The top level holds the FSM, the single-pass datapath, the flags and the handshakes.

## Test plan
All scenarios use WIDTH = 8.
- ADD 0xC8 + 0x64: result 0x12C, carry 1, overflow 0, zero 0; out_valid 1 cycle after accept.
- SUB 0x05 - 0x07: result 0x1FE, carry 1, overflow 0. SUB 0x80 - 0x01: result 0x07F, carry 0, overflow 1.
- ROTL 0x81 by 3: result 0x00C; out_valid exactly 4 cycles after accept. ROTL by 8 (amt 0): result 0x081 after 1 cycle.
- SHL 0xC0 by 1: result 0x180, carry 1. SHL 0xC0 by 9: same result. SHR 0x80 by 7: result 0x001. XOR 0x5A ^ 0x5A: zero 1.
- Hold out_ready low for 5 cycles in DONE:
  - result and flags stable, in_ready 0.
  - A concurrent in_valid is not accepted.
  - After out_ready rises, in_ready is 1 on the next cycle.
- Assert rst for 1 cycle during SHIFT (ROTL by 6):
  - Next cycle: out_valid 0, result 0, flags 0.
  - in_ready 1 after rst falls.
  - A new ADD completes correctly.
